uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
Parameters:
REQ-001 CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 BAUD, 9600, line bit rate in bit/s.
REQ-003 PARITY_EN, 0, 1 inserts a parity bit between data and stop.
REQ-004 PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.

Ports:
REQ-005 clk_i  input  1  single system clock, rising-edge active.
REQ-006 nreset_i  input  1  reset, asynchronous assert, active-low.
REQ-007 valid_i  input  1  producer has a byte on data_i.
REQ-008 ready_o  output  1  block can accept a byte this cycle.
REQ-009 data_i  input  8  byte to transmit, LSB first.
REQ-010 tx_o  output  1  serial line, idle high.
REQ-011 busy_o  output  1  frame in progress (any state other than IDLE).

Function
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD with integer truncation (10416 at defaults); a CLKS_PER_BIT below 2 SHALL be rejected at elaboration.
REQ-013 Bit-timer width SHALL be $clog2(CLKS_PER_BIT) and the timer SHALL count 0..CLKS_PER_BIT-1, then wrap to 0.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Transfer SHALL occur on a rising edge with valid_i=1 and ready_o=1; data_i SHALL be captured into a shift register on that edge.
REQ-016 ready_o SHALL be 1 only in IDLE; it is combinational from state and SHALL NOT depend on valid_i.
REQ-017 valid_i while ready_o=0 SHALL be ignored; no data is captured and no error is flagged.
REQ-018 IDLE->START on transfer; tx_o SHALL be 0 from the cycle after the transfer edge for exactly CLKS_PER_BIT cycles.
REQ-019 START->DATA after CLKS_PER_BIT cycles; DATA SHALL drive bits 0..7 in order, each for CLKS_PER_BIT cycles, counted by a 3-bit index.
REQ-020 DATA->PARITY after bit 7 if PARITY_EN=1, else DATA->STOP.
REQ-021 The parity bit SHALL be XOR of the captured byte for even parity and its inverse for odd parity, held for CLKS_PER_BIT cycles.
REQ-022 STOP SHALL drive tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle with tx_o=1.
REQ-024 tx_o SHALL be a registered output with no glitches between bit periods.
REQ-025 Changes on data_i after the transfer edge SHALL NOT affect the frame in flight.

Reset
REQ-026 Asserting nreset_i=0 SHALL immediately force IDLE, tx_o=1, ready_o=1, busy_o=0, bit timer=0, bit index=0, and shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no further line activity; after release, the first edge with valid_i=1 SHALL start a fresh frame.
REQ-028 Reset release SHALL be synchronised externally; the block requires no internal reset synchroniser.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the default CLK_FREQ/BAUD constants, and a CLKS_PER_BIT calculation function; the package is shared with uart_rx.
REQ-030 Sub-module uart_baud_gen SHALL contain the bit timer: it takes an enable and a clear, and outputs a one-cycle bit_done pulse on the count CLKS_PER_BIT-1.
REQ-031 The RTL SHALL be 120-400 lines in total, with no memories and no multi-clock logic.

Verification
Benches SHALL use CLK_FREQ=100, BAUD=10 (CLKS_PER_BIT=10) unless noted.
REQ-032 Reset check: hold nreset_i=0 for 5 cycles -> tx_o=1, ready_o=1, busy_o=0 throughout.
REQ-033 Single byte: send 8'h94 -> line 0,0,0,1,0,1,0,0,1,1 (start, LSB-first data, stop), each bit 10 cycles; ready_o=0 for 100 cycles; busy_o=1 for 100 cycles.
REQ-034 Back-to-back: hold valid_i=1 with 8'h94 then 8'h12 -> second start bit begins 101 cycles after the first; the receiving uart_rx outputs 8'h94 then 8'h12.
REQ-035 Parity: PARITY_EN=1, PARITY_ODD=0, send 8'h07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame 110 cycles.
REQ-036 Mid-frame reset: assert nreset_i during data bit 3 of 8'hA5 -> tx_o=1 within the same cycle; after release, a send of 8'h3C yields a clean full frame.
REQ-037 Default-parameter run: send 8'h55 at 100 MHz / 9600 -> each bit lasts 10416 cycles ±0 and the uart_rx loopback returns 8'h55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clocking constants and
// the bit-period calculation used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

  // Truncating division: the line runs slightly fast rather than slightly slow.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done for one cycle on the final count of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic en,
  input  logic clr,
  output logic bit_done
);

  localparam int                 TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(CLKS_PER_BIT - 1);

  logic [TIMER_W-1:0] count;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + TIMER_W'(1);
    end
  end

  assign bit_done = en && !clr && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, 8N1 framing with optional
// even/odd parity, registered glitch-free serial output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2 clocks per bit");
    end
  endgenerate

  uart_state_e state;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx;
  logic        bit_done;

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);

  // Timer is held at zero while idle so a frame's first bit is always full length.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .en      (busy_o),
    .clr     (ready_o),
    .bit_done(bit_done)
  );

  // NOTE: the captured byte is reset along with the control state so an
  // aborted frame leaves no stale data behind for the next transfer.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      shift_q <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            state   <= START;
            tx_o    <= 1'b0;
            shift_q <= data_i;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            tx_o  <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN) begin
                state <= PARITY;
                tx_o  <= (^shift_q) ^ PARITY_ODD;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              tx_o <= shift_q[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx_o  <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit: no-parity, even-parity
// and odd-parity instances against a frame-level line model and a sampling receiver.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk;
  logic       nreset;
  logic [2:0] valid;
  logic [7:0] data_r [3];
  wire  [2:0] tx_w;
  wire  [2:0] ready_w;
  wire  [2:0] busy_w;

  int tests = 0;
  int fails = 0;

  logic smp [240];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(100), .BAUD(10), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_plain (
    .clk_i(clk), .nreset_i(nreset), .valid_i(valid[0]), .ready_o(ready_w[0]),
    .data_i(data_r[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]));

  uart_tx #(.CLK_FREQ(100), .BAUD(10), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk_i(clk), .nreset_i(nreset), .valid_i(valid[1]), .ready_o(ready_w[1]),
    .data_i(data_r[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]));

  uart_tx #(.CLK_FREQ(100), .BAUD(10), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk_i(clk), .nreset_i(nreset), .valid_i(valid[2]), .ready_o(ready_w[2]),
    .data_i(data_r[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Line model: element k is the k-th bit on the wire (start, LSB-first data,
  // optional parity, stop); parity comes from counting ones.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input int inst);
    logic [10:0] f;
    int          ones;
    f    = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (inst == 0) begin
      f[9] = 1'b1;
    end else begin
      f[9]  = ((ones % 2) == 1) ^ (inst == 2);
      f[10] = 1'b1;
    end
    return f;
  endfunction

  // Receiver model: samples the middle of each bit period of a captured line.
  function automatic logic [8:0] rx_decode(input int start);
    logic [7:0] b;
    logic       framed;
    framed = (smp[start + 5] == 1'b0) && (smp[start + 9*CPB + 5] == 1'b1);
    for (int i = 0; i < 8; i++) b[i] = smp[start + (1+i)*CPB + 5];
    return {framed, b};
  endfunction

  task automatic run_frame(input int inst, input logic [7:0] d,
                           input logic [10:0] exp_line, input string tag);
    logic [10:0] line;
    int          nbits;
    int          bad;
    bit          got_ready;
    nbits     = (inst == 0) ? 10 : 11;
    line      = '0;
    bad       = 0;
    got_ready = 1'b0;
    for (int w = 0; w < 50 && !got_ready; w++) begin
      @(negedge clk);
      got_ready = ready_w[inst];
    end
    if (!got_ready) begin
      check({tag, "_ready_wait"}, 32'd0, 32'd1);
      return;
    end
    valid[inst]  = 1'b1;
    data_r[inst] = d;
    @(posedge clk);
    #1;
    valid[inst]  = 1'b0;
    data_r[inst] = ~d;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) line[k] = tx_w[inst];
        else if (tx_w[inst] !== line[k]) bad++;
        if (busy_w[inst] !== 1'b1 || ready_w[inst] !== 1'b0) bad++;
        // A request while busy must be ignored.
        if (k == 4 && c == 0) begin
          valid[inst]  = 1'b1;
          data_r[inst] = 8'h5A;
        end
        if (k == 4 && c == 1) valid[inst] = 1'b0;
      end
    end
    check({tag, "_line"}, 32'(line), 32'(exp_line));
    check({tag, "_stable"}, bad, 0);
    @(negedge clk);
    check({tag, "_idle"}, {tx_w[inst], ready_w[inst], busy_w[inst]}, 3'b110);
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [10:0] exp_line;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0]  rx;
    logic [7:0]  rd;
    int          ri;
    int          ready_at;
    int          quiet;

    nreset = 1'b0;
    valid  = '0;
    for (int i = 0; i < 3; i++) data_r[i] = '0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", {tx_w, ready_w, busy_w}, 9'b111_111_000);
    end
    nreset = 1'b1;

    // Expected lines: bit k of exp_line is the k-th bit on the wire.
    vecs[0] = '{0, 8'h94, 11'b0_1100101000};
    vecs[1] = '{1, 8'h07, 11'b11000001110};
    vecs[2] = '{2, 8'h07, 11'b10000001110};
    vecs[3] = '{0, 8'hA5, 11'b0_1101001010};
    vecs[4] = '{1, 8'hFF, 11'b10111111110};
    vecs[5] = '{2, 8'h00, 11'b11000000000};
    vecs[6] = '{1, 8'h00, 11'b10000000000};
    vecs[7] = '{2, 8'hFF, 11'b11111111110};
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].inst, vecs[v].data, vecs[v].exp_line, $sformatf("vec%0d", v));

    // Back-to-back: valid held high, second byte follows after one idle cycle.
    @(negedge clk);
    ready_at    = -1;
    valid[0]    = 1'b1;
    data_r[0]   = 8'h94;
    @(posedge clk);
    #1;
    data_r[0] = 8'h12;
    for (int s = 0; s < 240; s++) begin
      @(negedge clk);
      smp[s] = tx_w[0];
      if (ready_at < 0 && ready_w[0]) ready_at = s;
      else if (ready_at >= 0 && s == ready_at + 1) valid[0] = 1'b0;
    end
    valid[0] = 1'b0;
    check("b2b_ready_at", ready_at, 100);
    check("b2b_gap", {smp[99], smp[100], smp[101]}, 3'b110);
    check("b2b_rx0", rx_decode(0), {1'b1, 8'h94});
    check("b2b_rx1", rx_decode(101), {1'b1, 8'h12});

    // Mid-frame reset during data bit 3 of 8'hA5.
    @(negedge clk);
    valid[0]  = 1'b1;
    data_r[0] = 8'hA5;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (44) @(negedge clk);
    check("pre_reset_bit3", tx_w[0], 1'b0);
    nreset = 1'b0;
    #1;
    check("reset_async", {tx_w[0], ready_w[0], busy_w[0]}, 3'b110);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) quiet++;
    end
    check("reset_quiet", quiet, 0);
    nreset = 1'b1;
    run_frame(0, 8'h3C, ref_frame(8'h3C, 0), "after_reset");

    // Randomised frames across all three parity configurations.
    for (int r = 0; r < 12; r++) begin
      ri = int'($urandom_range(0, 2));
      rd = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(ri, rd, ref_frame(rd, ri), $sformatf("rand%0d_i%0d_%02h", r, ri, rd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
